// File: rtl/aes_round_key_gen.sv
// aes_round_key_gen: AES-128 round key streamer, forward K0..K10 or reverse K10..K0
// Ports: clk, rst_n (async, active low); start/enc/key begin a schedule from IDLE;
// next accepts the current round_key; round_key/round_idx/valid/last/busy are registered status.
// Optional macro AES_ROUND_KEY_GEN_REPLAY_EN adds input replay, which restarts the previous
// schedule from stored K0/K10 without the reverse-order preparation pass.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif
module aes_round_key_gen (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       enc,
  input  logic [`AES_BLOCK_SIZE-1:0] key,
  input  logic                       next,
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
  input  logic                       replay,
`endif
  output logic [`AES_BLOCK_SIZE-1:0] round_key,
  output logic [3:0]                 round_idx,
  output logic                       valid,
  output logic                       last,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE, PREP, STREAM} state_t;
  localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;
  localparam logic [127:0] RCON = {48'h0, 80'h01020408102040801b36};
  state_t state;
  logic dir;
  logic [3:0] cnt, rc_idx;
  logic [7:0] rc;
  logic [31:0] f4, f5, f6, f7, i4, i5, i6, i7;
  logic [127:0] step;
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
  logic [127:0] rp_k0, rp_k10;
  logic rp_ok;
`endif
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
  endfunction
  // PREP and forward streaming build round cnt/idx+1; reverse streaming undoes round 10-idx
  always_comb begin
    rc_idx = (state == PREP) ? cnt : dir ? round_idx : 4'd9 - round_idx;
    rc = RCON[{4'd9 - rc_idx, 3'b000} +: 8];
    f4 = round_key[127:96] ^ sub_rot(round_key[31:0]) ^ {rc, 24'h0};
    f5 = f4 ^ round_key[95:64];
    f6 = f5 ^ round_key[63:32];
    f7 = f6 ^ round_key[31:0];
    i7 = round_key[31:0] ^ round_key[63:32];
    i6 = round_key[63:32] ^ round_key[95:64];
    i5 = round_key[95:64] ^ round_key[127:96];
    i4 = round_key[127:96] ^ sub_rot(i7) ^ {rc, 24'h0};
    step = ((state == PREP) || dir) ? {f4, f5, f6, f7} : {i4, i5, i6, i7};
  end
  assign last = valid & (round_idx == 4'd10);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      valid <= 1'b0;
      dir <= 1'b1;
      cnt <= '0;
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
      rp_k0 <= '0;
      rp_k10 <= '0;
      rp_ok <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:
          if (start) begin
            dir <= enc;
            round_key <= key;
            round_idx <= '0;
            cnt <= '0;
            valid <= enc;
            state <= enc ? STREAM : PREP;
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
            rp_k0 <= key;
          end else if (replay && rp_ok) begin
            round_key <= dir ? rp_k0 : rp_k10;
            round_idx <= '0;
            valid <= 1'b1;
            state <= STREAM;
`endif
          end
        PREP: begin
          round_key <= step;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            valid <= 1'b1;
            state <= STREAM;
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
            rp_k10 <= step;
`endif
          end
        end
        STREAM:
          if (next) begin
            if (round_idx == 4'd10) begin
              valid <= 1'b0;
              state <= IDLE;
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
              rp_ok <= 1'b1;
              if (dir) rp_k10 <= round_key;
`endif
            end else begin
              round_key <= step;
              round_idx <= round_idx + 4'd1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes_round_key_gen.sv
// tb_aes_round_key_gen: randomized check of aes_round_key_gen against a FIPS-197 key expansion model
module tb_aes_round_key_gen;
  localparam logic [127:0] KAT = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KAT_K1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KAT_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic clk = 1'b0, rst_n, start, enc, next;
  logic [127:0] key, round_key;
  logic [3:0] round_idx;
  logic valid, last, busy;
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
  logic replay;
`endif
  int errors = 0, checks = 0;
  logic [7:0] sbox [256];
  logic [127:0] rk [11];
  logic [127:0] cur_key;
  aes_round_key_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enc(enc), .key(key), .next(next),
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
    .replay(replay),
`endif
    .round_key(round_key), .round_idx(round_idx), .valid(valid), .last(last), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction
  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    cur_key = k;
  endtask
  function automatic logic [127:0] rand128;
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic stream_check(input logic e, input bit rnd, input bit disturb);
    int idx = 0, guard = 0, r;
    bit nx;
    while (idx <= 10 && guard < 200) begin
      r = e ? idx : 10 - idx;
      chk("valid", 128'(valid), 128'(1));
      chk("busy", 128'(busy), 128'(1));
      chk($sformatf("key_r%0d", r), round_key, rk[r]);
      chk("idx", 128'(round_idx), 128'(idx));
      chk("last", 128'(last), 128'(idx == 10));
      if (cur_key == KAT && r == 1) chk("kat_k1", round_key, KAT_K1);
      if (cur_key == KAT && r == 10) chk("kat_k10", round_key, KAT_K10);
      nx = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      next = nx;
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        key = rand128();
        enc = ~e;
      end
      tick;
      next = 1'b0;
      start = 1'b0;
      if (nx) idx++;
      guard++;
    end
    chk("stream_timeout", 128'(guard < 200), 128'(1));
    chk("end_valid", 128'(valid), 128'(0));
    chk("end_busy", 128'(busy), 128'(0));
    chk("end_last", 128'(last), 128'(0));
  endtask
  task automatic run(input logic [127:0] k, input logic e, input bit rnd, input bit disturb);
    int lat = 0;
    expand(k);
    key = k;
    enc = e;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (!valid && lat < 20) begin
      if (disturb) begin
        start = 1'b1;
        key = rand128();
        enc = ~e;
      end
      tick;
      start = 1'b0;
      lat++;
    end
    chk("latency", 128'(lat), e ? 128'(0) : 128'(10));
    stream_check(e, rnd, disturb);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_key"}, round_key, 128'h0);
    chk({tag, "_idx"}, 128'(round_idx), 128'h0);
    chk({tag, "_valid"}, 128'(valid), 128'h0);
    chk({tag, "_last"}, 128'(last), 128'h0);
    chk({tag, "_busy"}, 128'(busy), 128'h0);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    enc = 1'b1;
    key = '0;
    next = 1'b0;
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
    replay = 1'b0;
`endif
    build_sbox();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    run(KAT, 1'b1, 1'b0, 1'b0);
    run(KAT, 1'b0, 1'b0, 1'b0);
    run(KAT, 1'b1, 1'b1, 1'b1);
    run(KAT, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++)
      run(rand128(), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    key = rand128();
    enc = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    chk("prep_busy", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1 check_zero("rst_prep");
    #1 rst_n = 1'b1;
    run(rand128(), 1'b0, 1'b1, 1'b0);
    key = rand128();
    enc = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    next = 1'b1;
    repeat (4) tick;
    next = 1'b0;
    chk("mid_idx", 128'(round_idx), 128'(4));
    #2 rst_n = 1'b0;
    #1 check_zero("rst_stream");
    #1 rst_n = 1'b1;
    run(KAT, 1'b1, 1'b0, 1'b0);
`ifdef AES_ROUND_KEY_GEN_REPLAY_EN
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    replay = 1'b1;
    tick;
    replay = 1'b0;
    chk("replay_cold_valid", 128'(valid), 128'(0));
    chk("replay_cold_busy", 128'(busy), 128'(0));
    run(KAT, 1'b0, 1'b0, 1'b0);
    replay = 1'b1;
    tick;
    replay = 1'b0;
    chk("replay_key", round_key, KAT_K10);
    stream_check(1'b0, 1'b1, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
